// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI bus (SCLK, MOSI, per-device SS) between
// the flash master (0) and the light-sensor master (1).
module spi_bus_arbiter #(
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1023,
  parameter int CNT_W      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  output logic [1:0] req_timeout,
  output logic [1:0] m_valid,
  input  logic [1:0] m_ready,
  input  logic [1:0] m_sclk,
  input  logic [1:0] m_ss,
  input  logic [1:0] m_mosi,
  output logic       bus_sclk,
  output logic [1:0] bus_ss,
  output logic       bus_mosi,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       m_valid_q, m_valid_d;
  logic [1:0]       req_ready_q, req_ready_d;
  logic [1:0]       req_timeout_q, req_timeout_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       eligible;
  logic             winner;
  logic             done_ok;

  // A request seen in the same cycle as its own completion is the old one still held.
  assign eligible = req_valid & ~req_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      m_valid_q     <= 2'b00;
      req_ready_q   <= 2'b00;
      req_timeout_q <= 2'b00;
      last_q        <= 1'b1;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      m_valid_q     <= m_valid_d;
      req_ready_q   <= req_ready_d;
      req_timeout_q <= req_timeout_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    m_valid_d     = 2'b00;
    req_ready_d   = 2'b00;
    req_timeout_d = 2'b00;
    last_d        = last_q;
    cnt_d         = cnt_q;
    winner        = 1'b0;
    done_ok       = m_ready[grant_q[1]];

    case (state_q)
      IDLE: begin
        if (eligible != 2'b00) begin
          winner    = (eligible == 2'b11) ? ~last_q : eligible[1];
          grant_d   = winner ? 2'b10 : 2'b01;
          m_valid_d = winner ? 2'b10 : 2'b01;
          last_d    = winner;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        // A done pulse on the final cycle still wins over the timeout.
        if (done_ok || (cnt_q == TIMEOUT_LAST)) begin
          req_ready_d   = grant_q;
          req_timeout_d = done_ok ? 2'b00 : grant_q;
          grant_d       = 2'b00;
          cnt_d         = '0;
          state_d       = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant       = grant_q;
  assign m_valid     = m_valid_q;
  assign req_ready   = req_ready_q;
  assign req_timeout = req_timeout_q;
  assign busy        = (state_q == ISSUE) || (state_q == BUSY);

  assign bus_ss[0] = grant_q[0] ? m_ss[0] : 1'b1;
  assign bus_ss[1] = grant_q[1] ? m_ss[1] : 1'b1;
  assign bus_sclk  = |(grant_q & m_sclk);
  assign bus_mosi  = |(grant_q & m_mosi);

endmodule
